gpio_irq_controller: RTL
========================

Name: gpio_irq_controller

Overview:
- Memory-mapped, parametrised GPIO peripheral for the Risco-5 SoC bus.
- Successor to the fixed-width GPIO port, adding:
  - per-pin direction;
  - atomic set/clear of outputs;
  - configurable input synchroniser depth;
  - per-pin rising/falling edge interrupts with sticky write-1-to-clear pending bits and a single interrupt line to the core.

Parameters:
- GPIO_WIDTH, 8, number of pins (1..32).
- SYNC_STAGES, 2, input synchroniser flops per pin (2..4).
- BASE_ADDR, 32'h0000_0000, match on address[31:8]; word offset in address[7:2].

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rd  input  1  read request, single-cycle strobe.
- wr  input  1  write request, single-cycle strobe.
- address  input  32  byte address.
- write_data  input  32  write data.
- read_data  output  32  read data, valid while response=1.
- response  output  1  one-cycle acknowledge.
- gpios  inout  GPIO_WIDTH  pads; driven when dir bit=1, else high-Z.
- irq  output  1  level interrupt = |(pending & irq_en).

Behaviour:
- Reset (reset=0, asynchronous) clears to 0:
  - out, dir, irq_en, rise_en, fall_en, pending, sync chains, edge_prev, warm-up counter;
  - outputs read_data=0, response=0, irq=0.
- All pins are inputs after reset.
- Register map (offset from BASE_ADDR):
  - 0x00 IN: RO, synchronised pad values.
  - 0x04 OUT: RW.
  - 0x08 DIR: RW, 1=output.
  - 0x0C OUT_SET: WO, OUT |= wdata.
  - 0x10 OUT_CLR: WO, OUT &= ~wdata.
  - 0x14 IRQ_EN: RW.
  - 0x18 RISE_EN: RW.
  - 0x1C FALL_EN: RW.
  - 0x20 PENDING: R/W1C.
- Bits at index >= GPIO_WIDTH: writes ignored, reads return 0. WO registers read 0.
- Unmapped offset inside the 256-byte window: write ignored, read 0, response still given.
- Address outside the window: no response.
- Handshake:
  - rd or wr at cycle N → response=1 at cycle N+1 for exactly one cycle; read_data registered with it.
  - read_data returns to 0 the cycle after.
  - rd and wr asserted together: treated as a write, read_data=0.
  - A new strobe in the response cycle is accepted normally, giving back-to-back response.
- Input path:
  - Pad → SYNC_STAGES flop chain → sync.
  - IN reflects a pad change SYNC_STAGES cycles later.
  - Output pins read back their driven value through the pad.
- Edge detection:
  - edge_prev <= sync every cycle.
  - rise = sync & ~edge_prev & rise_en; fall = ~sync & edge_prev & fall_en.
  - Both enables set gives both-edge mode.
  - Detection applies regardless of dir.
- Warm-up:
  - A counter holds detection disabled for SYNC_STAGES+1 cycles after reset release, so pins already high at reset do not raise false rising edges.
  - The counter saturates and does not re-arm until the next reset.
- Pending:
  - pending[i] set the cycle after the edge is visible on sync; stays set until cleared.
  - Set is independent of irq_en, so a later enable fires immediately.
  - W1C and a new edge on the same bit in the same cycle: set wins, bit stays 1.
- irq is combinational from registered pending/irq_en: asserts the same cycle pending latches, deasserts the cycle after W1C.
- Reset asserted mid-transaction: response and read_data forced 0 immediately; the transaction is lost.
- DIR change from 1→0: pad released the next cycle. OUT contents retained.

Test Plan:
- Reset release with pads[7:4]=4'b1010, RISE_EN=0xFF, IRQ_EN=0xFF written after warm-up → PENDING reads 0x00, irq=0 (no false edges).
- Write DIR=0x0F, OUT=0x05; read IN with pads[7:4]=1010 → read_data=0x000000A5, response high exactly 1 cycle, 1 cycle after rd.
- OUT_SET 0x0A then OUT_CLR 0x01 → OUT reads 0x0E; gpios[3:0]=4'b1110.
- RISE_EN=0x10, IRQ_EN=0x10; drive gpios[4] 0→1 → PENDING=0x10 after SYNC_STAGES+1 cycles, irq=1. Write PENDING=0x10 → irq=0 next cycle.
- FALL_EN=RISE_EN=0x80; toggle gpios[7] in the same cycle as a W1C of bit 7 becomes visible → PENDING[7] stays 1.
- rd to BASE_ADDR+0x3C → response=1, read_data=0. rd to an address outside the window → response stays 0.

Source files
------------

// File: rtl/gpio_irq_controller.sv
// gpio_irq_controller: memory-mapped GPIO with direction, set/clear, input sync and edge interrupts
module gpio_irq_controller #(
  parameter int          GPIO_WIDTH  = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  response,
  inout  wire  [GPIO_WIDTH-1:0] gpios,
  output logic                  irq
);
  localparam int          W     = GPIO_WIDTH;
  localparam logic [5:0]  O_IN  = 6'h00;
  localparam logic [5:0]  O_OUT = 6'h01;
  localparam logic [5:0]  O_DIR = 6'h02;
  localparam logic [5:0]  O_SET = 6'h03;
  localparam logic [5:0]  O_CLR = 6'h04;
  localparam logic [5:0]  O_IEN = 6'h05;
  localparam logic [5:0]  O_REN = 6'h06;
  localparam logic [5:0]  O_FEN = 6'h07;
  localparam logic [5:0]  O_PND = 6'h08;
  localparam logic [2:0]  WARM  = 3'(SYNC_STAGES + 1);

  logic [W-1:0] out, dir, irq_en, rise_en, fall_en, pending;
  logic [W-1:0] sync, edge_prev, wdata, rise, fall, rdata;
  logic [SYNC_STAGES-1:0][W-1:0] chain;
  logic [2:0] warm;
  logic [5:0] off;
  logic hit, wen, ren, armed;

  assign hit   = address[31:8] == BASE_ADDR[31:8];
  assign off   = address[7:2];
  assign wen   = wr & hit;
  assign ren   = rd & ~wr & hit;
  assign wdata = write_data[W-1:0];
  assign sync  = chain[SYNC_STAGES-1];
  assign armed = warm == WARM;
  assign rise  = sync & ~edge_prev & rise_en;
  assign fall  = ~sync & edge_prev & fall_en;
  assign irq   = |(pending & irq_en);

  for (genvar g = 0; g < W; g++) begin : g_pad
    assign gpios[g] = dir[g] ? out[g] : 1'bz;
  end

  // register read mux; write-only and unmapped offsets read as zero
  always_comb begin
    case (off)
      O_IN:    rdata = sync;
      O_OUT:   rdata = out;
      O_DIR:   rdata = dir;
      O_IEN:   rdata = irq_en;
      O_REN:   rdata = rise_en;
      O_FEN:   rdata = fall_en;
      O_PND:   rdata = pending;
      default: rdata = '0;
    endcase
  end

  // pad synchroniser, edge history and post-reset warm-up counter that masks start-up edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain     <= '0;
      edge_prev <= '0;
      warm      <= '0;
    end else begin
      chain     <= {chain[SYNC_STAGES-2:0], gpios};
      edge_prev <= sync;
      warm      <= armed ? warm : warm + 3'd1;
    end
  end

  // bus handshake and register file; a new edge wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      response  <= 1'b0;
      read_data <= '0;
      out       <= '0;
      dir       <= '0;
      irq_en    <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
      pending   <= '0;
    end else begin
      response  <= (rd | wr) & hit;
      read_data <= ren ? 32'(rdata) : '0;
      out       <= !wen ? out : off == O_OUT ? wdata : off == O_SET ? out | wdata :
                   off == O_CLR ? out & ~wdata : out;
      dir       <= wen && off == O_DIR ? wdata : dir;
      irq_en    <= wen && off == O_IEN ? wdata : irq_en;
      rise_en   <= wen && off == O_REN ? wdata : rise_en;
      fall_en   <= wen && off == O_FEN ? wdata : fall_en;
      pending   <= (pending & ~(wen && off == O_PND ? wdata : '0)) | (armed ? rise | fall : '0);
    end
  end
endmodule
